ysyx_24090018_mem_arbiter: RTL and testbench
============================================

// Module: ysyx_24090018_mem_arbiter
// PURPOSE
//  Shares a single memory port between the IFU (fetch, read-only) and the LSU
//  (load/store). Arbitrates, registers the granted request and drives it
//  downstream with valid/ready handshakes. Tracks the one outstanding
//  transaction and routes its response back to the owner. Sits between
//  IFU/mem_access and the memory/bus model in the multi-cycle core.
// PARAMETERS
//  ADDR_WIDTH  32  address width, all ports
//  DATA_WIDTH  32  data width; mask width = DATA_WIDTH/8
// PORTS
//  clk               in   1   clock, all state on rising edge
//  rst               in   1   asynchronous, active-low reset
//  ifu_req_valid_i   in   1   IFU fetch request
//  ifu_req_ready_o   out  1   IFU request accepted this cycle
//  ifu_addr_i        in   AW  fetch address
//  ifu_resp_valid_o  out  1   fetch data valid
//  ifu_resp_ready_i  in   1   IFU takes response
//  ifu_rdata_o       out  DW  fetched instruction
//  lsu_req_valid_i   in   1   LSU request
//  lsu_req_ready_o   out  1   LSU request accepted this cycle
//  lsu_addr_i        in   AW  load/store address
//  lsu_wen_i         in   1   1=store, 0=load
//  lsu_wdata_i       in   DW  store data
//  lsu_wmask_i       in   DW/8 byte strobes (stores)
//  lsu_resp_valid_o  out  1   load data / store ack valid
//  lsu_resp_ready_i  in   1   LSU takes response
//  lsu_rdata_o       out  DW  load data
//  mem_req_valid_o   out  1   downstream request
//  mem_req_ready_i   in   1   downstream accepts request
//  mem_addr_o / mem_wen_o / mem_wdata_o / mem_wmask_o  out  AW/1/DW/DW/8
//  mem_resp_valid_i  in   1   downstream response
//  mem_resp_ready_o  out  1   response accepted by owner
//  mem_rdata_i       in   DW  response data
//  busy_o            out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> REQ -> RESP -> IDLE; owner reg {IFU,LSU}. One outstanding txn.
//  - Reset (rst=0, async): state=IDLE, all *_valid_o/ *_ready_o/busy_o=0,
//    mem_* payload=0, last_owner=LSU. In-flight txn dropped, no response
//    forwarded; downstream is reset by the same rst.
//  - IDLE: grant chosen combinationally; granted req_ready_o=1 only if its
//    req_valid_i=1; other ready=0. Handshake latches addr/wen/wdata/wmask
//    (IFU: wen=0, wmask=0, wdata=0), sets owner, -> REQ. No valid -> stay.
//  - REQ: mem_req_valid_o=1, payload from latches, held stable until
//    mem_req_ready_i=1 -> RESP. Both upstream req_ready_o=0.
//  - RESP: owner resp_valid_o=mem_resp_valid_i, owner rdata_o=mem_rdata_i,
//    mem_resp_ready_o=owner resp_ready_i; non-owner resp_valid_o=0.
//    Resp handshake -> IDLE, last_owner<=owner. Stores also get a response.
//  - Latency: accept (cycle 0), mem_req_valid_o from cycle 1; zero-wait mem
//    => response cycle 2, next accept cycle 3. Max 1 txn / 3 cycles.
//  - Upstream valid dropped before accept: nothing latched. Input changes
//    after accept do not affect the in-flight txn.
//  - rdata_o of non-owner and outside RESP = 0.
// CONFIGURATION
//  YSYX_ARB_RR_EN defined: round-robin; both valid in IDLE -> grant the
//    requester != last_owner (after reset IFU first). Single valid -> it.
//  undefined: fixed priority, LSU wins whenever lsu_req_valid_i=1;
//    last_owner still kept but unused.
// TESTING
//  1 IFU only, addr=0x8000_0000, mem ready/resp immediate, rdata=0x0010_0093
//    -> ifu_req_ready cycle0, mem_req_valid cycle1, ifu_resp_valid cycle2
//    with rdata 0x0010_0093, busy_o=1 cycles1-2, accept again cycle3.
//  2 LSU store addr=0x8000_1000 wdata=0xDEAD_BEEF wmask=4'b0011 -> mem
//    payload exact, mem_wen_o=1, lsu_resp_valid pulses, ifu_resp_valid=0.
//  3 Both valid every cycle, 4 txns: fixed -> LSU,LSU,LSU,LSU; with
//    YSYX_ARB_RR_EN -> IFU,LSU,IFU,LSU.
//  4 mem_req_ready_i low 5 cycles, then lsu_resp_ready_i low 3 cycles ->
//    payload stable, valids held, no new grant until both complete.
//  5 rst=0 asserted in REQ mid-cycle -> outputs 0 immediately (no clock
//    edge); after release first grant as from reset, no stale response.

Source files
------------

// File: rtl/ysyx_24090018_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port, one transaction in flight.
// Define YSYX_ARB_RR_EN for round-robin arbitration; otherwise the LSU has fixed priority.
module ysyx_24090018_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid_i,
  output logic                    ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr_i,
  output logic                    ifu_resp_valid_o,
  input  logic                    ifu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   ifu_rdata_o,
  input  logic                    lsu_req_valid_i,
  output logic                    lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
  input  logic                    lsu_wen_i,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask_i,
  output logic                    lsu_resp_valid_o,
  input  logic                    lsu_resp_ready_i,
  output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_wen_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_resp_valid_i,
  output logic                    mem_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic                      owner_lsu;
  logic                      grant_lsu;
  logic                      ifu_acc, lsu_acc, resp_hs;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      wen_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wmask_q;

`ifdef YSYX_ARB_RR_EN
  // Grant history only matters when both masters contend; reset favours the IFU.
  logic last_owner_lsu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_owner_lsu <= 1'b1;
    else if (resp_hs) last_owner_lsu <= owner_lsu;
  end

  assign grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || !last_owner_lsu);
`else
  assign grant_lsu = lsu_req_valid_i;
`endif

  // Ready is gated by rst so nothing is accepted while reset is held.
  assign ifu_acc = (state == IDLE) && rst && !grant_lsu && ifu_req_valid_i;
  assign lsu_acc = (state == IDLE) && rst && grant_lsu;
  assign resp_hs = mem_resp_valid_i && mem_resp_ready_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state <= state_nxt;
      if (ifu_acc) begin
        owner_lsu <= 1'b0;
        addr_q    <= ifu_addr_i;
        wen_q     <= 1'b0;
        wdata_q   <= '0;
        wmask_q   <= '0;
      end else if (lsu_acc) begin
        owner_lsu <= 1'b1;
        addr_q    <= lsu_addr_i;
        wen_q     <= lsu_wen_i;
        wdata_q   <= lsu_wdata_i;
        wmask_q   <= lsu_wmask_i;
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    ifu_req_ready_o  = 1'b0;
    lsu_req_ready_o  = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    ifu_resp_valid_o = 1'b0;
    lsu_resp_valid_o = 1'b0;
    ifu_rdata_o      = '0;
    lsu_rdata_o      = '0;
    case (state)
      IDLE: begin
        ifu_req_ready_o = ifu_acc;
        lsu_req_ready_o = lsu_acc;
        if (ifu_acc || lsu_acc) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_nxt = RESP;
      end
      RESP: begin
        if (owner_lsu) begin
          lsu_resp_valid_o = mem_resp_valid_i;
          lsu_rdata_o      = mem_rdata_i;
          mem_resp_ready_o = lsu_resp_ready_i;
        end else begin
          ifu_resp_valid_o = mem_resp_valid_i;
          ifu_rdata_o      = mem_rdata_i;
          mem_resp_ready_o = ifu_resp_ready_i;
        end
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wen_o   = wen_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_24090018_mem_arbiter.sv
// Scoreboard bench for ysyx_24090018_mem_arbiter with a simple memory model on the downstream port.
// Honours YSYX_ARB_RR_EN to choose the expected grant order.
module tb_ysyx_24090018_mem_arbiter;

  logic        clk, rst;
  logic        ifu_req_valid_i, ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_ready_i;
  logic [31:0] ifu_addr_i, ifu_rdata_o;
  logic        lsu_req_valid_i, lsu_req_ready_o, lsu_wen_i, lsu_resp_valid_o, lsu_resp_ready_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [3:0]  lsu_wmask_i, mem_wmask_o;
  logic        mem_req_valid_o, mem_req_ready_i, mem_wen_o, mem_resp_valid_i, mem_resp_ready_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        busy_o;

  ysyx_24090018_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i), .ifu_resp_valid_o(ifu_resp_valid_o),
    .ifu_resp_ready_i(ifu_resp_ready_i), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wmask_i(lsu_wmask_i), .lsu_resp_valid_o(lsu_resp_valid_o),
    .lsu_resp_ready_i(lsu_resp_ready_i), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  req_t        req_q[$];
  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];
  req_t        mon_req;
  logic [31:0] mon_data;
  int          tests = 0;
  int          fails = 0;

  // Memory model: returns 0x0010_0093 at the reset vector, {a[15:0], ~a[15:0]} elsewhere.
  logic        mem_ready_en;
  logic        pending;
  logic [31:0] resp_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) pending <= 1'b0;
    else if (pending && mem_resp_valid_i && mem_resp_ready_o) pending <= 1'b0;
    else if (mem_req_valid_o && mem_req_ready_i) begin
      pending   <= 1'b1;
      resp_addr <= mem_addr_o;
    end
  end

  assign mem_req_ready_i  = mem_ready_en;
  assign mem_resp_valid_i = pending;
  assign mem_rdata_i      = !pending ? 32'h0 :
                            (resp_addr == 32'h8000_0000) ? 32'h0010_0093 :
                            {resp_addr[15:0], ~resp_addr[15:0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input string why);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got %s", name, why);
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    req_t r;
    r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
    req_q.push_back(r);
  endtask

  // Drivers are called just after a rising edge and return just after the accepting edge.
  task automatic applyStimulusIfu(input logic [31:0] a);
    bit got = 0;
    ifu_req_valid_i = 1'b1;
    ifu_addr_i      = a;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (ifu_req_ready_o) got = 1;
      @(posedge clk); #1;
    end
    ifu_req_valid_i = 1'b0;
    if (!got) note_fail("ifu_accept", "timeout, expected accept");
  endtask

  task automatic applyStimulusLsu(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    bit got = 0;
    lsu_req_valid_i = 1'b1;
    lsu_addr_i = a; lsu_wen_i = w; lsu_wdata_i = d; lsu_wmask_i = m;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (lsu_req_ready_o) got = 1;
      @(posedge clk); #1;
    end
    lsu_req_valid_i = 1'b0;
    if (!got) note_fail("lsu_accept", "timeout, expected accept");
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_o || req_q.size() != 0 || ifu_q.size() != 0 || lsu_q.size() != 0) && n < 300);
    if (n >= 300) note_fail(name, "timeout, expected idle and empty scoreboard");
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every downstream request and upstream response handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (req_q.size() == 0) note_fail("mem_req", "unexpected request");
        else begin
          mon_req = req_q.pop_front();
          check("mem_addr",  mem_addr_o,  mon_req.addr);
          check("mem_wen",   mem_wen_o,   mon_req.wen);
          check("mem_wdata", mem_wdata_o, mon_req.wdata);
          check("mem_wmask", mem_wmask_o, mon_req.wmask);
        end
      end
      if (ifu_resp_valid_o && ifu_resp_ready_i) begin
        if (ifu_q.size() == 0) note_fail("ifu_resp", "unexpected response");
        else begin
          mon_data = ifu_q.pop_front();
          check("ifu_rdata", ifu_rdata_o, mon_data);
        end
      end
      if (lsu_resp_valid_o && lsu_resp_ready_i) begin
        if (lsu_q.size() == 0) note_fail("lsu_resp", "unexpected response");
        else begin
          mon_data = lsu_q.pop_front();
          check("lsu_rdata", lsu_rdata_o, mon_data);
        end
      end
      check("resp_exclusive", ifu_resp_valid_o & lsu_resp_valid_o, 0);
    end
    if (!ifu_resp_valid_o) check("ifu_rdata_quiet", ifu_rdata_o, 0);
    if (!lsu_resp_valid_o) check("lsu_rdata_quiet", lsu_rdata_o, 0);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    ifu_req_valid_i = 0; ifu_addr_i = 0; ifu_resp_ready_i = 1;
    lsu_req_valid_i = 0; lsu_addr_i = 0; lsu_wen_i = 0; lsu_wdata_i = 0; lsu_wmask_i = 0;
    lsu_resp_ready_i = 1;
    mem_ready_en = 1'b1;

    #3;
    checkOutput("rst_mem_valid", mem_req_valid_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_mem_wen", mem_wen_o, 0);
    ifu_req_valid_i = 1'b1;
    lsu_req_valid_i = 1'b1;
    #1;
    checkOutput("rst_ifu_ready", ifu_req_ready_o, 0);
    checkOutput("rst_lsu_ready", lsu_req_ready_o, 0);
    ifu_req_valid_i = 1'b0;
    lsu_req_valid_i = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Test 1: IFU fetch timing with a zero-wait memory.
    push_req(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    push_req(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    ifu_q.push_back(32'h0010_0093);
    ifu_q.push_back(32'h0010_0093);
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000;
    @(negedge clk);
    checkOutput("t1_c0_ifu_ready", ifu_req_ready_o, 1);
    checkOutput("t1_c0_busy", busy_o, 0);
    @(posedge clk); #1;
    ifu_req_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("t1_c1_mem_valid", mem_req_valid_o, 1);
    checkOutput("t1_c1_busy", busy_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t1_c2_ifu_resp_valid", ifu_resp_valid_o, 1);
    checkOutput("t1_c2_ifu_rdata", ifu_rdata_o, 32'h0010_0093);
    checkOutput("t1_c2_busy", busy_o, 1);
    @(posedge clk); #1;
    ifu_req_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("t1_c3_ifu_ready", ifu_req_ready_o, 1);
    @(posedge clk); #1;
    ifu_req_valid_i = 1'b0;
    waitIdle("t1_idle");

    // Test 2: LSU store, response routed only to the LSU.
    push_req(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    lsu_q.push_back(32'h1000_EFFF);
    applyStimulusLsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
    waitIdle("t2_idle");

    // Test 3: both masters request continuously, starting from a fresh reset.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef YSYX_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      push_req(32'h8000_0100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
      push_req(32'h8000_2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
    end
`else
    for (int i = 0; i < 4; i++) push_req(32'h8000_2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) push_req(32'h8000_0100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
`endif
    ifu_q.push_back(32'h0100_FEFF); ifu_q.push_back(32'h0104_FEFB);
    ifu_q.push_back(32'h0108_FEF7); ifu_q.push_back(32'h010C_FEF3);
    lsu_q.push_back(32'h2000_DFFF); lsu_q.push_back(32'h2004_DFFB);
    lsu_q.push_back(32'h2008_DFF7); lsu_q.push_back(32'h200C_DFF3);
    fork
      for (int i = 0; i < 4; i++) applyStimulusIfu(32'h8000_0100 + 32'(4 * i));
      for (int i = 0; i < 4; i++) applyStimulusLsu(32'h8000_2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
    join
    waitIdle("t3_idle");

    // Test 4: downstream stall then upstream response backpressure.
    push_req(32'h8000_3000, 1'b1, 32'h1234_5678, 4'hF);
    push_req(32'h8000_0200, 1'b0, 32'h0, 4'h0);
    lsu_q.push_back(32'h3000_CFFF);
    ifu_q.push_back(32'h0200_FDFF);
    mem_ready_en = 1'b0;
    lsu_resp_ready_i = 1'b0;
    fork
      applyStimulusLsu(32'h8000_3000, 1'b1, 32'h1234_5678, 4'hF);
      begin
        repeat (2) @(posedge clk);
        #1;
        applyStimulusIfu(32'h8000_0200);
      end
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checkOutput("t4_stall_mem_valid", mem_req_valid_o, 1);
          checkOutput("t4_stall_addr", mem_addr_o, 32'h8000_3000);
          checkOutput("t4_stall_wdata", mem_wdata_o, 32'h1234_5678);
          checkOutput("t4_stall_ifu_ready", ifu_req_ready_o, 0);
          @(posedge clk); #1;
        end
        mem_ready_en = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("t4_hold_lsu_valid", lsu_resp_valid_o, 1);
          checkOutput("t4_hold_lsu_rdata", lsu_rdata_o, 32'h3000_CFFF);
          checkOutput("t4_hold_mem_valid", mem_req_valid_o, 0);
          checkOutput("t4_hold_ifu_ready", ifu_req_ready_o, 0);
          @(posedge clk); #1;
        end
        lsu_resp_ready_i = 1'b1;
      end
    join
    waitIdle("t4_idle");

    // Test 5: asynchronous reset while a fetch is parked in REQ.
    mem_ready_en = 1'b0;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0400;
    @(negedge clk);
    checkOutput("t5_ifu_ready", ifu_req_ready_o, 1);
    @(posedge clk); #1;
    ifu_req_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("t5_in_req", mem_req_valid_o, 1);
    #2;
    rst = 1'b0;
    ifu_req_valid_i = 1'b1; ifu_addr_i = 32'h8000_0500;
    lsu_req_valid_i = 1'b1; lsu_addr_i = 32'h8000_4000;
    lsu_wen_i = 1'b0; lsu_wdata_i = 32'h0; lsu_wmask_i = 4'h0;
    #1;
    checkOutput("t5_rst_mem_valid", mem_req_valid_o, 0);
    checkOutput("t5_rst_busy", busy_o, 0);
    checkOutput("t5_rst_mem_addr", mem_addr_o, 0);
    checkOutput("t5_rst_ifu_ready", ifu_req_ready_o, 0);
    checkOutput("t5_rst_lsu_ready", lsu_req_ready_o, 0);
    mem_ready_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
`ifdef YSYX_ARB_RR_EN
    push_req(32'h8000_0500, 1'b0, 32'h0, 4'h0);
    push_req(32'h8000_4000, 1'b0, 32'h0, 4'h0);
`else
    push_req(32'h8000_4000, 1'b0, 32'h0, 4'h0);
    push_req(32'h8000_0500, 1'b0, 32'h0, 4'h0);
`endif
    ifu_q.push_back(32'h0500_FAFF);
    lsu_q.push_back(32'h4000_BFFF);
    fork
      applyStimulusIfu(32'h8000_0500);
      applyStimulusLsu(32'h8000_4000, 1'b0, 32'h0, 4'h0);
    join
    waitIdle("t5_idle");

    checkOutput("end_req_q_empty", req_q.size(), 0);
    checkOutput("end_ifu_q_empty", ifu_q.size(), 0);
    checkOutput("end_lsu_q_empty", lsu_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
